// File: rtl/alu_top.sv
// Registered N-bit integer ALU for the execute stage.
// Operands are sampled each rising edge; result and {S,Z,C,V} flags appear one edge later.
module alu_top #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   operacion,
    output logic [N-1:0] resultado,
    output logic [3:0]   flagsResult
);

    localparam int unsigned SW = $clog2(N);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_MOD = 4'b0100,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SHL = 4'b1000,
        OP_SHR = 4'b1001
    } op_e;

    op_e            op;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [2*N-1:0] prod;
    logic [N:0]     shl_w;
    logic [N:0]     shr_w;
    logic           b_zero;

    logic [N-1:0]   res_d, res_q;
    logic [3:0]     flags_d, flags_q;
    logic           carry, ovf;

    assign op     = op_e'(operacion);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign prod   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    assign b_zero = (b == '0);

    // One guard bit on each side captures the last bit shifted out (0 for a zero shift).
    assign shl_w  = {1'b0, a} << b[SW-1:0];
    assign shr_w  = {a, 1'b0} >> b[SW-1:0];

    always_comb begin
        res_d = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res_d = sum[N-1:0];
                carry = sum[N];
                ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                res_d = diff[N-1:0];
                carry = diff[N];
                ovf   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_MUL: begin
                res_d = prod[N-1:0];
                carry = (prod[2*N-1:N] != '0);
                ovf   = (prod[2*N-1:N] != '0);
            end
            OP_DIV: begin
                res_d = b_zero ? '1 : (a / b);
                ovf   = b_zero;
            end
            OP_MOD: begin
                res_d = b_zero ? a : (a % b);
                ovf   = b_zero;
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_SHL: begin
                res_d = shl_w[N-1:0];
                carry = shl_w[N];
            end
            OP_SHR: begin
                res_d = shr_w[N:1];
                carry = shr_w[0];
            end
            default: res_d = '0;
        endcase
        flags_d = {res_d[N-1], (res_d == '0), carry, ovf};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign resultado   = res_q;
    assign flagsResult = flags_q;

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: expected results are queued when inputs are driven
// and compared one edge later, using spec constants and an independent bit-serial model.
module tb_alu_top;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  operacion;
    logic [31:0] resultado;
    logic [3:0]  flagsResult;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    alu_top #(.N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .operacion   (operacion),
        .resultado   (resultado),
        .flagsResult (flagsResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit/signed arithmetic and one-bit-at-a-time shifting.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop,
                                  output logic [31:0] r, output logic [3:0] f);
        logic [63:0] w;
        longint      s;
        logic        c;
        logic        v;
        int unsigned amt;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (mop)
            4'd0: begin
                w = {32'd0, ma} + {32'd0, mb};
                r = w[31:0];
                c = w[32];
                s = longint'($signed(ma)) + longint'($signed(mb));
                v = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
                r = ma - mb;
                c = (ma < mb);
                s = longint'($signed(ma)) - longint'($signed(mb));
                v = (s > SMAX) || (s < SMIN);
            end
            4'd2: begin
                w = {32'd0, ma} * {32'd0, mb};
                r = w[31:0];
                c = (w[63:32] != 32'd0);
                v = c;
            end
            4'd3: begin
                if (mb == 32'd0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
                else r = ma / mb;
            end
            4'd4: begin
                if (mb == 32'd0) begin r = ma; v = 1'b1; end
                else r = ma % mb;
            end
            4'd5: r = ma & mb;
            4'd6: r = ma | mb;
            4'd7: r = ma ^ mb;
            4'd8: begin
                amt = mb % 32;
                r = ma;
                for (int unsigned k = 0; k < amt; k++) begin
                    c = r[31];
                    r = r << 1;
                end
            end
            4'd9: begin
                amt = mb % 32;
                r = ma;
                for (int unsigned k = 0; k < amt; k++) begin
                    c = r[0];
                    r = r >> 1;
                end
            end
            default: r = 32'd0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop,
                         input logic irst, input logic [31:0] er, input logic [3:0] ef, input string tag);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        operacion = iop;
        rst = irst;
        e.r = er;
        e.f = ef;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic drive_m(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
        logic [31:0] er;
        logic [3:0]  ef;
        model(ia, ib, iop, er, ef);
        drive(ia, ib, iop, 1'b0, er, ef, $sformatf("rnd_op%0h", iop));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_res"}, resultado, e.r);
            check({e.tag, "_flg"}, {28'd0, flagsResult}, {28'd0, e.f});
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        a = 32'd7;
        b = 32'd3;
        operacion = 4'b0000;

        drive(32'd7, 32'd3, 4'h0, 1'b1, 32'd0, 4'b0000, "reset0");
        drive(32'd7, 32'd3, 4'h0, 1'b1, 32'd0, 4'b0000, "reset1");
        drive(32'd7, 32'd3, 4'h0, 1'b0, 32'd10, 4'b0000, "post_reset");

        drive(32'd10,        32'd20,        4'h0, 1'b0, 32'd30,        4'b0000, "add_pos");
        drive(-32'sd15,      -32'sd20,      4'h0, 1'b0, 32'hFFFF_FFDD, 4'b1010, "add_neg");
        drive(32'h7FFF_FFFF, 32'd1,         4'h0, 1'b0, 32'h8000_0000, 4'b1001, "add_ovf");
        drive(32'd10,        32'd30,        4'h1, 1'b0, 32'hFFFF_FFEC, 4'b1010, "sub_borrow");
        drive(32'd50,        32'd25,        4'h1, 1'b0, 32'd25,        4'b0000, "sub_pos");
        drive(32'd9,         32'd9,         4'h1, 1'b0, 32'd0,         4'b0100, "sub_zero");
        drive(32'h8000_0000, 32'd1,         4'h1, 1'b0, 32'h7FFF_FFFF, 4'b0001, "sub_ovf");
        drive(32'd5,         32'd0,         4'h2, 1'b0, 32'd0,         4'b0100, "mul_zero");
        drive(32'h0001_0000, 32'h0001_0000, 4'h2, 1'b0, 32'd0,         4'b0111, "mul_hi");
        drive(32'd25,        32'd5,         4'h3, 1'b0, 32'd5,         4'b0000, "div");
        drive(32'd30,        32'd7,         4'h4, 1'b0, 32'd2,         4'b0000, "mod");
        drive(32'd9,         32'd0,         4'h3, 1'b0, 32'hFFFF_FFFF, 4'b1001, "div0");
        drive(32'd9,         32'd0,         4'h4, 1'b0, 32'd9,         4'b0001, "mod0");
        drive(32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 1'b0, 32'h00F0_000F, 4'b0000, "and");
        drive(32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h6, 1'b0, 32'hFFF0_0FFF, 4'b1000, "or");
        drive(32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h7, 1'b0, 32'hFF00_0FF0, 4'b1000, "xor");
        drive(32'h8000_0001, 32'd1,         4'h8, 1'b0, 32'd2,         4'b0010, "shl1");
        drive(32'h8000_0001, 32'd32,        4'h8, 1'b0, 32'h8000_0001, 4'b1000, "shl_wrap0");
        drive(32'h0000_0003, 32'd31,        4'h8, 1'b0, 32'h8000_0000, 4'b1010, "shl31");
        drive(32'h8000_0003, 32'd1,         4'h9, 1'b0, 32'h4000_0001, 4'b0010, "shr1");
        drive(32'h8000_0000, 32'd31,        4'h9, 1'b0, 32'd1,         4'b0000, "shr31");
        drive(32'd123,       32'd456,       4'hA, 1'b0, 32'd0,         4'b0100, "op_a");
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0,         4'b0100, "op_f");
        drive(32'd100,       32'd1,         4'h0, 1'b1, 32'd0,         4'b0000, "reset_prio");

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 7 == 0) ra = {1'b0, ra[30:0]};
            drive_m(ra, rb, rop);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
